packet_rr_arbiter: RTL and testbench

Packet-locked round-robin arbiter that shares one router output channel among five input ports (Local, North, East, West, South). A grant is won with a header flit. It is held until that port's tail flit is forwarded, and transfers are gated by a downstream credit counter. A per-lock watchdog frees the channel when the owner stalls. One instance sits in front of each router output port, replacing fixed-priority, length-timed arbitration.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/packet_rr_arbiter_if.sv | 27 ++
 rtl/packet_rr_arbiter_rr_picker.sv | 27 ++
 rtl/packet_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_packet_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encodings, port indices and
// the output-arbiter state encoding.
package noc_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;
  localparam logic [2:0] FLIT_SINGLE = 3'b101;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned PORT_S = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/packet_rr_arbiter_if.sv
// Bundle between the input ports / downstream credit return and one output
// channel arbiter. slave = arbiter side, master = upstream/driver side.
interface packet_rr_arbiter_if #(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned CREDITS = 4
);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [NPORTS-1:0]   req;
  logic [3*NPORTS-1:0] flit_id;
  logic                credit_ret;
  logic [NPORTS-1:0]   grant;
  logic [2:0]          owner;
  logic                fwd;
  logic [CW-1:0]       credits;
  logic                timeout_err;

  modport slave (
    input  req, flit_id, credit_ret,
    output grant, owner, fwd, credits, timeout_err
  );

  modport master (
    output req, flit_id, credit_ret,
    input  grant, owner, fwd, credits, timeout_err
  );
endinterface

// File: rtl/packet_rr_arbiter_rr_picker.sv
// Combinational rotating-priority select: searches from i_start+1 upward,
// wrapping modulo NPORTS, and returns the first set request.
module rr_picker #(
  parameter int unsigned NPORTS = 5,
  parameter int unsigned IW     = 3
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [IW-1:0]     i_start,
  output logic              o_valid,
  output logic [IW-1:0]     o_idx
);

  always_comb begin
    logic [IW-1:0] v_idx;
    o_valid = 1'b0;
    o_idx   = '0;
    v_idx   = '0;
    for (int unsigned off = 1; off <= NPORTS; off++) begin
      v_idx = IW'((32'(i_start) + off) % NPORTS);
      if (!o_valid && i_req[v_idx]) begin
        o_valid = 1'b1;
        o_idx   = v_idx;
      end
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-locked round-robin arbiter for one router output channel, with
// downstream credit gating and a per-lock stall watchdog.
module packet_rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  packet_rr_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  arb_state_t        r_state, w_state_nxt;
  logic [NPORTS-1:0] r_grant, w_grant_nxt;
  logic [2:0]        r_owner, w_owner_nxt;
  logic [2:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]     r_credits, w_credits_nxt;
  logic [WW-1:0]     r_wdog, w_wdog_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;

  logic [NPORTS-1:0] w_cand;
  logic              w_pick_valid;
  logic [2:0]        w_pick_idx;
  logic              w_owner_req;
  logic [2:0]        w_owner_type;
  logic              w_fwd, w_tail, w_timeout;

  // Only headers (incl. single-flit) may open a lock; owner flit is muxed
  // with constant indices to keep the select widths exact.
  always_comb begin
    w_cand       = '0;
    w_owner_req  = 1'b0;
    w_owner_type = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      w_cand[i] = bus.req[i] & (|(bus.flit_id[3*i +: 3] & FLIT_HEADER));
      if (r_owner == 3'(i)) begin
        w_owner_req  = bus.req[i];
        w_owner_type = bus.flit_id[3*i +: 3];
      end
    end
  end

  rr_picker #(
    .NPORTS (NPORTS),
    .IW     (3)
  ) u_picker (
    .i_req   (w_cand),
    .i_start (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_fwd     = (r_state == LOCKED) && w_owner_req && (r_credits != '0);
  assign w_tail    = w_fwd && (|(w_owner_type & FLIT_TAIL));
  assign w_timeout = (r_state == LOCKED) && !w_fwd && (r_wdog == WW'(TIMEOUT));

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_nxt       = r_owner;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_wdog_nxt        = r_wdog;
    w_timeout_err_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt              = LOCKED;
          w_owner_nxt              = w_pick_idx;
          w_grant_nxt              = '0;
          w_grant_nxt[w_pick_idx]  = 1'b1;
          w_wdog_nxt               = '0;
        end
      end
      LOCKED: begin
        if (w_tail || w_timeout) begin
          w_state_nxt       = IDLE;
          w_grant_nxt       = '0;
          w_owner_nxt       = '0;
          w_rr_ptr_nxt      = r_owner;
          w_wdog_nxt        = '0;
          w_timeout_err_nxt = w_timeout;
        end else if (w_fwd) begin
          w_wdog_nxt = '0;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_credits_nxt = r_credits;
    unique case ({w_fwd, bus.credit_ret})
      2'b10: w_credits_nxt = r_credits - 1'b1;
      2'b01: if (r_credits != CW'(CREDITS)) w_credits_nxt = r_credits + 1'b1;
      default: w_credits_nxt = r_credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= 3'(NPORTS - 1);
      r_credits     <= CW'(CREDITS);
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_credits     <= w_credits_nxt;
      r_wdog        <= w_wdog_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;
  assign bus.fwd         = w_fwd;
  assign bus.credits     = r_credits;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter: per-port flit queues model the
// upstream, and a scoreboard of expected (port, flit type) transfers.
module tb_packet_rr_arbiter;
  import noc_pkg::*;

  localparam int unsigned NP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_rr_arbiter_if #(.NPORTS(NP), .CREDITS(4)) bus ();

  packet_rr_arbiter #(
    .NPORTS  (NP),
    .CREDITS (4),
    .TIMEOUT (1023)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_terr   = 0;

  logic [2:0]  fq [NP][0:31];
  int unsigned fh [NP];
  int unsigned ft [NP];
  logic [5:0]  exp_q [$];

  logic [NP-1:0] s_grant;
  logic [2:0]    s_owner, s_type;
  logic          s_fwd, s_terr;
  logic [2:0]    s_credits;
  int            s_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_flit(input int p, input logic [2:0] t, input bit expect_fwd);
    fq[p][ft[p]] = t;
    ft[p]++;
    if (expect_fwd) exp_q.push_back({3'(p), t});
  endtask

  // One clock cycle: present queue heads, sample mid-cycle, score transfers.
  task automatic tick();
    logic [5:0] e;
    for (int i = 0; i < NP; i++) begin
      bus.req[i]           = (fh[i] != ft[i]);
      bus.flit_id[3*i +: 3] = (fh[i] != ft[i]) ? fq[i][fh[i]] : 3'b000;
    end
    #3;
    s_grant   = bus.grant;
    s_owner   = bus.owner;
    s_fwd     = bus.fwd;
    s_terr    = bus.timeout_err;
    s_credits = bus.credits;
    s_type    = bus.flit_id[3*s_owner +: 3];
    s_cyc     = cyc;
    if (!rst && s_terr === 1'b1) n_terr++;
    if (!rst && s_fwd === 1'b1) begin
      fh[s_owner]++;
      chk("fwd_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fwd_port", 32'(s_owner), 32'(e[5:3]));
        chk("fwd_type", 32'(s_type), 32'(e[2:0]));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) begin
      fh[i] = 0;
      ft[i] = 0;
    end
    exp_q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int tl, gn, k, terr0;
    int fc [$];
    bus.req        = '0;
    bus.flit_id    = '0;
    bus.credit_ret = 1'b1;
    @(posedge clk);
    #1;

    // T1: L and N headers together; L packet first, N two cycles after L tail
    do_reset();
    push_flit(PORT_L, FLIT_HEADER, 1); push_flit(PORT_L, FLIT_BODY, 1); push_flit(PORT_L, FLIT_TAIL, 1);
    push_flit(PORT_N, FLIT_HEADER, 1); push_flit(PORT_N, FLIT_TAIL, 1);
    tick();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_owner", 32'(s_owner), 32'd0);
    chk("rst_credits", 32'(s_credits), 32'd4);
    chk("rst_terr", 32'(s_terr), 32'd0);
    chk("idle_fwd", 32'(s_fwd), 32'd0);
    tick();
    chk("t1_grant_l", 32'(s_grant), 32'b00001);
    chk("t1_fwd_hdr", 32'(s_fwd), 32'd1);
    tl = -100; gn = -1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      tick();
      if (s_fwd === 1'b1 && s_owner == 3'd0 && s_type[2]) tl = s_cyc;
      if (s_grant === 5'b00010 && gn < 0) gn = s_cyc;
    end
    chk("t1_drain", 32'(exp_q.size()), 32'd0);
    chk("t1_n_after_l_tail", 32'(gn - tl), 32'd2);

    // T2: all ports with single-flit packets, rotating order with bubbles
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_flit(p, FLIT_SINGLE, 1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tick();
      if (s_fwd === 1'b1) fc.push_back(s_cyc);
    end
    chk("t2_drain", 32'(exp_q.size()), 32'd0);
    chk("t2_count", 32'(fc.size()), 32'd10);
    for (int i = 1; i < fc.size(); i++) chk("t2_spacing", 32'(fc[i] - fc[i-1]), 32'd2);
    chk("t2_credits", 32'(s_credits), 32'd4);

    // T3: credit exhaustion mid-packet, then two single returns
    do_reset();
    bus.credit_ret = 1'b0;
    push_flit(PORT_W, FLIT_HEADER, 1);
    for (int i = 0; i < 4; i++) push_flit(PORT_W, FLIT_BODY, 1);
    push_flit(PORT_W, FLIT_TAIL, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_fwd_with_credit", 32'(s_fwd), 32'd1);
    end
    tick();
    chk("t3_stall_fwd", 32'(s_fwd), 32'd0);
    chk("t3_stall_grant", 32'(s_grant), 32'b01000);
    chk("t3_stall_credits", 32'(s_credits), 32'd0);
    bus.credit_ret = 1'b1;
    tick();
    chk("t3_ret_not_yet_visible", 32'(s_fwd), 32'd0);
    bus.credit_ret = 1'b0;
    tick();
    chk("t3_fwd_after_ret", 32'(s_fwd), 32'd1);
    chk("t3_credits_1", 32'(s_credits), 32'd1);
    bus.credit_ret = 1'b1;
    tick();
    chk("t3_stall2_fwd", 32'(s_fwd), 32'd0);
    bus.credit_ret = 1'b0;
    tick();
    chk("t3_tail_fwd", 32'(s_fwd), 32'd1);
    tick();
    chk("t3_end_grant", 32'(s_grant), 32'd0);
    chk("t3_end_credits", 32'(s_credits), 32'd0);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // T4: credit saturation at 4 and fwd+return cancellation at 2
    do_reset();
    bus.credit_ret = 1'b1;
    tick();
    bus.credit_ret = 1'b0;
    push_flit(PORT_S, FLIT_HEADER, 1);
    for (int i = 0; i < 3; i++) push_flit(PORT_S, FLIT_BODY, 1);
    push_flit(PORT_S, FLIT_TAIL, 1);
    tick();
    chk("t4_saturate", 32'(s_credits), 32'd4);
    tick();
    tick();
    bus.credit_ret = 1'b1;
    tick();
    chk("t4_pre_cancel", 32'(s_credits), 32'd2);
    chk("t4_cancel_fwd", 32'(s_fwd), 32'd1);
    bus.credit_ret = 1'b0;
    tick();
    chk("t4_after_cancel", 32'(s_credits), 32'd2);
    tick();
    tick();
    chk("t4_drain", 32'(exp_q.size()), 32'd0);
    chk("t4_end_credits", 32'(s_credits), 32'd0);

    // T5: owner stalls after header; watchdog release, next port after owner
    do_reset();
    bus.credit_ret = 1'b1;
    push_flit(PORT_E, FLIT_HEADER, 1);
    tick();
    tick();
    chk("t5_grant_e", 32'(s_grant), 32'b00100);
    chk("t5_hdr_fwd", 32'(s_fwd), 32'd1);
    push_flit(PORT_N, FLIT_HEADER, 0);
    push_flit(PORT_W, FLIT_HEADER, 1);
    terr0 = n_terr;
    k = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (s_grant === 5'b00000) begin
        k = i;
        break;
      end
    end
    chk("t5_release_delay", 32'(k), 32'd1025);
    chk("t5_terr_pulse", 32'(s_terr), 32'd1);
    tick();
    chk("t5_terr_one_cycle", 32'(s_terr), 32'd0);
    chk("t5_grant_w", 32'(s_grant), 32'b01000);
    chk("t5_terr_count", 32'(n_terr - terr0), 32'd1);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // T6: reset mid-packet drops the lock; E header beats stranded N body
    do_reset();
    bus.credit_ret = 1'b0;
    push_flit(PORT_N, FLIT_HEADER, 1);
    push_flit(PORT_N, FLIT_BODY, 1);
    push_flit(PORT_N, FLIT_BODY, 0);
    push_flit(PORT_N, FLIT_TAIL, 0);
    tick();
    tick();
    tick();
    chk("t6_credits_pre", 32'(s_credits), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_flit(PORT_E, FLIT_HEADER, 1);
    push_flit(PORT_E, FLIT_TAIL, 1);
    tick();
    chk("t6_grant_cleared", 32'(s_grant), 32'd0);
    chk("t6_credits_restored", 32'(s_credits), 32'd4);
    tick();
    chk("t6_grant_e", 32'(s_grant), 32'b00100);
    tick();
    tick();
    chk("t6_no_n_grant_1", 32'(s_grant), 32'd0);
    tick();
    chk("t6_no_n_grant_2", 32'(s_grant), 32'd0);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);
    chk("other_terr", 32'(n_terr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
